uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive-buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 1000, clk cycles the receiver stays disabled after a BREAK.
REQ-003 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ctrl_en  input  1  software enable for reception.
REQ-006 SHALL have port ctrl_clear  input  1  one-cycle pulse; flushes FIFO and clears sticky flags.
REQ-007 SHALL have port rx_valid  input  1  from uart_rx: one-cycle pulse, frame received.
REQ-008 SHALL have port rx_break  input  1  from uart_rx: frame was a BREAK, qualified by rx_valid.
REQ-009 SHALL have port rx_data  input  8  from uart_rx: received byte, qualified by rx_valid.
REQ-010 SHALL have port uart_rx_en  output  1  receive enable driven to uart_rx.
REQ-011 SHALL have port out_valid  output  1  FIFO head byte available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head byte.
REQ-013 SHALL have port out_data  output  8  FIFO head byte.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
REQ-015 SHALL have ports overrun, break_seen  output  1 each  sticky status flags.

Function
REQ-016 SHALL implement states DISABLED, RUN, HOLDOFF; uart_rx_en = 1 only in RUN.
REQ-017 DISABLED -> RUN when ctrl_en = 1; RUN or HOLDOFF -> DISABLED when ctrl_en = 0 (next cycle).
REQ-018 RUN -> HOLDOFF on rx_valid & rx_break; holdoff counter loads HOLDOFF_CYCLES-1.
REQ-019 HOLDOFF decrements counter each cycle; at 0 -> RUN if ctrl_en, else DISABLED.
REQ-020 Push: rx_valid & ~rx_break in RUN writes rx_data to tail; rx_valid outside RUN ignored.
REQ-021 BREAK frames SHALL never be stored; break_seen set to 1 the cycle after the break frame.
REQ-022 FIFO SHALL be first-word-fall-through: out_data = head entry whenever out_valid = 1.
REQ-023 out_valid = (fifo_level != 0); pop occurs on out_valid & out_ready, level decrements next cycle.
REQ-024 out_data SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-025 Push and pop same cycle: level unchanged, both performed, including when full.
REQ-026 Push when full with no pop: byte dropped, FIFO contents unchanged, overrun set to 1.
REQ-027 Pop when empty: no effect; level never below 0 or above FIFO_DEPTH.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH without corrupting order.
REQ-029 ctrl_clear: next cycle level = 0, out_valid = 0, overrun = 0, break_seen = 0; state unchanged.
REQ-030 ctrl_clear coincident with push or set condition: clear wins, byte and flag discarded.
REQ-031 Entering DISABLED SHALL NOT flush FIFO; buffered bytes remain poppable.
REQ-032 Latency rx_valid -> out_valid (empty FIFO) SHALL be exactly 1 clk cycle.

Reset
REQ-033 resetn = 0 SHALL asynchronously force state DISABLED, uart_rx_en = 0, level 0, out_valid = 0, overrun = 0, break_seen = 0, holdoff counter 0.
REQ-034 out_data value under reset is don't-care; FIFO storage needs no reset.
REQ-035 Reset mid-HOLDOFF or mid-FIFO activity SHALL discard all state; after release, first ctrl_en = 1 enters RUN next cycle.

Verification
REQ-036 Enable, push 0x55, 0xA3, 0x00 with out_ready = 0 -> level 3, out_data 0x55; raise out_ready -> pops 0x55, 0xA3, 0x00 in order, level 0.
REQ-037 FIFO_DEPTH = 4, push 5 bytes 0x01..0x05, no pops -> level 4, overrun = 1, pops yield 0x01..0x04.
REQ-038 Full FIFO, push 0x77 with out_ready = 1 same cycle -> level stays 4, overrun = 0, 0x77 last out.
REQ-039 rx_valid & rx_break (rx_data 0x00) in RUN -> nothing stored, break_seen = 1, uart_rx_en = 0 for exactly 1000 cycles, then 1.
REQ-040 20 push/pop pairs of random bytes with FIFO_DEPTH = 4 (pointer wrap) -> output order equals input order, no overrun.
REQ-041 resetn pulsed low during HOLDOFF with 2 bytes buffered -> uart_rx_en = 0, level 0, flags 0 immediately, before next clk edge.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-enable sequencer with BREAK holdoff and a first-word-fall-through byte FIFO
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int HOLDOFF_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          ctrl_en,
   input  logic                          ctrl_clear,
   input  logic                          rx_valid,
   input  logic                          rx_break,
   input  logic [7:0]                    rx_data,
   output logic                          uart_rx_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   output logic                          break_seen
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
   typedef enum logic [1:0] {DISABLED, RUN, HOLDOFF} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rp, wp;
   logic full, push_req, push, pop, brk;
   assign uart_rx_en = state == RUN;
   assign out_valid  = fifo_level != '0;
   assign out_data   = mem[rp];
   assign full       = fifo_level == (AW+1)'(FIFO_DEPTH);
   assign push_req   = uart_rx_en & rx_valid & ~rx_break;
   assign brk        = uart_rx_en & rx_valid & rx_break;
   assign pop        = out_valid & out_ready;
   // a full FIFO still accepts a byte when the head leaves in the same cycle
   assign push       = push_req & (~full | pop) & ~ctrl_clear;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == DISABLED) state_nx = ctrl_en ? RUN : DISABLED;
      else if (!ctrl_en) begin
         state_nx = DISABLED;
         cnt_nx   = '0;
      end else if (state == RUN && brk) begin
         state_nx = HOLDOFF;
         cnt_nx   = CW'(HOLDOFF_CYCLES - 1);
      end else if (state == HOLDOFF) begin
         if (cnt == '0) state_nx = RUN;
         else cnt_nx = cnt - 1'b1;
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= DISABLED;
         cnt        <= '0;
         rp         <= '0;
         wp         <= '0;
         fifo_level <= '0;
         overrun    <= 1'b0;
         break_seen <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (ctrl_clear) begin
            rp         <= '0;
            wp         <= '0;
            fifo_level <= '0;
            overrun    <= 1'b0;
            break_seen <= 1'b0;
         end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push && !pop) fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (push_req && full && !pop) overrun <= 1'b1;
            if (brk) break_seen <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= rx_data;
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl (FIFO_DEPTH 4, HOLDOFF_CYCLES 1000)
module tb_uart_rx_ctrl;
   logic clk = 1'b0, resetn = 1'b0, ctrl_en = 1'b0, ctrl_clear = 1'b0;
   logic rx_valid = 1'b0, rx_break = 1'b0, out_ready = 1'b0;
   logic [7:0] rx_data = '0;
   logic uart_rx_en, out_valid, overrun, break_seen;
   logic [7:0] out_data;
   logic [2:0] fifo_level;
   int errors = 0, checks = 0;
   logic [7:0] q [$];
   logic [7:0] d, e;
   int n;

   uart_rx_ctrl #(.FIFO_DEPTH(4), .HOLDOFF_CYCLES(1000)) dut (
      .clk(clk), .resetn(resetn), .ctrl_en(ctrl_en), .ctrl_clear(ctrl_clear),
      .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
      .uart_rx_en(uart_rx_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .fifo_level(fifo_level), .overrun(overrun), .break_seen(break_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic brk);
      rx_valid = 1'b1;
      rx_data  = b;
      rx_break = brk;
      tick();
      rx_valid = 1'b0;
      rx_break = 1'b0;
   endtask

   initial begin
      #3;
      chk("rst_en", uart_rx_en, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_brk", break_seen, 0);
      tick();
      resetn  = 1'b1;
      ctrl_en = 1'b1;
      tick();
      chk("enable_run", uart_rx_en, 1);
      // basic ordering with a stalled consumer, 1-cycle latency
      send(8'h55, 1'b0);
      chk("latency_valid", out_valid, 1);
      chk("latency_data", out_data, 8'h55);
      send(8'hA3, 1'b0);
      send(8'h00, 1'b0);
      chk("three_level", fifo_level, 3);
      tick();
      chk("stall_data", out_data, 8'h55);
      out_ready = 1'b1;
      tick();
      chk("pop1_data", out_data, 8'hA3);
      chk("pop1_level", fifo_level, 2);
      tick();
      chk("pop2_data", out_data, 8'h00);
      tick();
      chk("drained_level", fifo_level, 0);
      chk("drained_valid", out_valid, 0);
      tick();
      chk("empty_pop_level", fifo_level, 0);
      out_ready = 1'b0;
      // overrun: fifth byte is dropped
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
      chk("ovr_level", fifo_level, 4);
      chk("ovr_flag", overrun, 1);
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("ovr_pop", out_data, i);
         tick();
      end
      chk("ovr_drained", fifo_level, 0);
      out_ready  = 1'b0;
      ctrl_clear = 1'b1;
      tick();
      ctrl_clear = 1'b0;
      chk("clear_ovr", overrun, 0);
      chk("clear_keeps_run", uart_rx_en, 1);
      // clear wins over a coincident push
      ctrl_clear = 1'b1;
      send(8'h5A, 1'b0);
      ctrl_clear = 1'b0;
      chk("clear_vs_push", fifo_level, 0);
      // full FIFO with simultaneous push and pop
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      chk("full_level", fifo_level, 4);
      out_ready = 1'b1;
      send(8'h77, 1'b0);
      out_ready = 1'b0;
      chk("fullpp_level", fifo_level, 4);
      chk("fullpp_ovr", overrun, 0);
      out_ready = 1'b1;
      foreach (q[i]) q.delete(i);
      q = '{8'h22, 8'h33, 8'h44, 8'h77};
      for (int i = 0; i < 4; i++) begin
         chk("fullpp_order", out_data, q[i]);
         tick();
      end
      out_ready = 1'b0;
      chk("fullpp_drained", fifo_level, 0);
      // BREAK: nothing stored, receiver off for exactly 1000 cycles
      send(8'h00, 1'b1);
      chk("brk_en", uart_rx_en, 0);
      chk("brk_seen", break_seen, 1);
      chk("brk_level", fifo_level, 0);
      n = 1;
      for (int k = 0; k < 2000 && !uart_rx_en; k++) begin
         tick();
         if (!uart_rx_en) n++;
      end
      chk("holdoff_cycles", n, 1000);
      chk("holdoff_done", uart_rx_en, 1);
      ctrl_clear = 1'b1;
      tick();
      ctrl_clear = 1'b0;
      chk("clear_brk", break_seen, 0);
      // disabled: pushes ignored
      ctrl_en = 1'b0;
      tick();
      chk("disabled_en", uart_rx_en, 0);
      send(8'h99, 1'b0);
      chk("disabled_push", fifo_level, 0);
      ctrl_en = 1'b1;
      tick();
      chk("reenable", uart_rx_en, 1);
      // pointer wrap: one resident byte, 20 simultaneous push/pop pairs
      q.delete();
      d = 8'($urandom);
      q.push_back(d);
      send(d, 1'b0);
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         q.push_back(d);
         e = q.pop_front();
         chk("wrap_order", out_data, e);
         out_ready = 1'b1;
         send(d, 1'b0);
         out_ready = 1'b0;
      end
      chk("wrap_level", fifo_level, 1);
      chk("wrap_ovr", overrun, 0);
      chk("wrap_last", out_data, q[0]);
      // reset during HOLDOFF with buffered bytes
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'h00, 1'b1);
      tick();
      tick();
      chk("pre_rst_level", fifo_level, 3);
      #2 resetn = 1'b0;
      #1;
      chk("async_en", uart_rx_en, 0);
      chk("async_level", fifo_level, 0);
      chk("async_valid", out_valid, 0);
      chk("async_brk", break_seen, 0);
      chk("async_ovr", overrun, 0);
      tick();
      resetn = 1'b1;
      tick();
      chk("post_rst_run", uart_rx_en, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
